// File: rtl/obi_mem_responder_pkg.sv
// Shared types and helpers for the OBI memory responder.
// The response record travels through the latency pipeline and the response FIFO.
package obi_mem_responder_pkg;

    localparam int OBI_BE_W = 4;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } obi_rsp_t;

    // Merge new_w into old_w, taking only the byte lanes whose enable is set.
    function automatic logic [31:0] be_merge(input logic [31:0]         old_w,
                                             input logic [31:0]         new_w,
                                             input logic [OBI_BE_W-1:0] be);
        logic [31:0] res;
        for (int i = 0; i < OBI_BE_W; i++) begin
            res[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/obi_mem_responder_if.sv
// OBI address/response channel bundle between an initiator (master)
// and a subordinate (slave).
interface obi_mem_responder_if;
    import obi_mem_responder_pkg::*;

    logic                req;
    logic                gnt;
    logic [31:0]         addr;
    logic                we;
    logic [OBI_BE_W-1:0] be;
    logic [31:0]         wdata;
    logic                rvalid;
    logic                rready;
    logic [31:0]         rdata;
    logic                err;

    modport master (output req, addr, we, be, wdata, rready,
                    input  gnt, rvalid, rdata, err);
    modport slave  (input  req, addr, we, be, wdata, rready,
                    output gnt, rvalid, rdata, err);

endinterface

// File: rtl/obi_mem_responder_rsp_fifo.sv
// Generic first-word-fall-through FIFO: the head entry is visible on rdata_o
// whenever the FIFO is not empty; storage itself is not reset.
module obi_mem_responder_rsp_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic [31:0]
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic push_i,
    input  logic pop_i,
    output logic full_o,
    output logic empty_o,
    input  T     wdata_i,
    output T     rdata_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    T              mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push_ok, pop_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign pop_ok  = pop_i && !empty_o;
    // A push into a full FIFO is only legal when the head leaves the same cycle.
    assign push_ok = push_i && (!full_o || pop_i);
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q;
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/obi_mem_responder.sv
// OBI subordinate backed by a single-port word memory, with programmable grant
// delay, response latency and outstanding-transaction limit; responses stay in order.
module obi_mem_responder
    import obi_mem_responder_pkg::*;
#(
    parameter int          MEM_WORDS       = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int          GNT_DELAY       = 0,
    parameter int          RSP_LATENCY     = 1,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    obi_mem_responder_if.slave  obi
);

    localparam int AW  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int OCW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OCW-1:0] MAX_OUT_W = OCW'(MAX_OUTSTANDING);

    if (RSP_LATENCY < 1) begin : g_bad_latency
        $fatal(1, "obi_mem_responder: RSP_LATENCY must be >= 1");
    end
    if (MAX_OUTSTANDING < 1) begin : g_bad_outstanding
        $fatal(1, "obi_mem_responder: MAX_OUTSTANDING must be >= 1");
    end

    logic [31:0]    mem_q [MEM_WORDS];
    logic [32:0]    diff;
    logic [1:0]     unused_lsb;
    logic           in_range;
    logic [AW-1:0]  idx;
    logic           gnt_en_q;
    logic           delay_ok;
    logic           gnt, hs, retire;
    logic [OCW-1:0] outst_q, outst_d;
    obi_rsp_t       acc_rsp, fifo_wdata, fifo_head;
    logic           fifo_push, fifo_empty, unused_full;

    // A 33-bit difference exposes addresses below BASE_ADDR through the borrow bit.
    assign diff       = {1'b0, obi.addr} - {1'b0, BASE_ADDR};
    assign unused_lsb = diff[1:0];
    assign in_range   = !diff[32] && ({3'b000, diff[31:2]} < 33'(MEM_WORDS));
    assign idx        = diff[AW+1:2];

    if (GNT_DELAY == 0) begin : g_no_delay
        assign delay_ok = 1'b1;
    end else begin : g_delay
        localparam int WCW = $clog2(GNT_DELAY + 1);
        localparam logic [WCW-1:0] GNT_DELAY_W = WCW'(GNT_DELAY);
        logic [WCW-1:0] wait_cnt_q, wait_cnt_d;

        always_comb begin
            wait_cnt_d = wait_cnt_q;
            if (!obi.req || hs) begin
                wait_cnt_d = '0;
            end else if (wait_cnt_q != GNT_DELAY_W) begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) wait_cnt_q <= '0;
            else          wait_cnt_q <= wait_cnt_d;
        end

        assign delay_ok = (wait_cnt_q == GNT_DELAY_W);
    end

    // gnt_en_q keeps the combinational grant low while reset is applied.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) gnt_en_q <= 1'b0;
        else          gnt_en_q <= 1'b1;
    end

    assign gnt    = gnt_en_q && obi.req && delay_ok && (outst_q < MAX_OUT_W);
    assign hs     = gnt;
    assign retire = !fifo_empty && obi.rready;

    always_comb begin
        acc_rsp.rdata = '0;
        acc_rsp.err   = !in_range;
        if (in_range && !obi.we) begin
            acc_rsp.rdata = mem_q[idx];
        end
    end

    always_ff @(posedge clk_i) begin
        if (hs && obi.we && in_range) begin
            mem_q[idx] <= be_merge(mem_q[idx], obi.wdata, obi.be);
        end
    end

    if (RSP_LATENCY == 1) begin : g_direct
        assign fifo_push  = hs;
        assign fifo_wdata = acc_rsp;
    end else begin : g_pipe
        localparam int NS = RSP_LATENCY - 1;
        logic [NS-1:0] vld_q;
        obi_rsp_t      rsp_q [NS];

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                vld_q <= '0;
                for (int i = 0; i < NS; i++) rsp_q[i] <= '0;
            end else begin
                vld_q[0] <= hs;
                rsp_q[0] <= acc_rsp;
                for (int i = 1; i < NS; i++) begin
                    vld_q[i] <= vld_q[i-1];
                    rsp_q[i] <= rsp_q[i-1];
                end
            end
        end

        assign fifo_push  = vld_q[NS-1];
        assign fifo_wdata = rsp_q[NS-1];
    end

    // The outstanding limit also covers entries still in the pipeline, so the FIFO never overflows.
    obi_mem_responder_rsp_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .T     (obi_rsp_t)
    ) u_rsp_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (fifo_push),
        .pop_i   (retire),
        .full_o  (unused_full),
        .empty_o (fifo_empty),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_head)
    );

    always_comb begin
        outst_d = outst_q;
        case ({hs, retire})
            2'b10:   outst_d = outst_q + OCW'(1);
            2'b01:   outst_d = outst_q - OCW'(1);
            default: outst_d = outst_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) outst_q <= '0;
        else          outst_q <= outst_d;
    end

    assign obi.gnt    = gnt;
    assign obi.rvalid = !fifo_empty;
    assign obi.rdata  = fifo_empty ? 32'h0 : fifo_head.rdata;
    assign obi.err    = fifo_empty ? 1'b0  : fifo_head.err;

endmodule
